// File: rtl/clock_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : clock_ctrl_pkg
// Brief    : Shared mode encoding, field limits and helpers for the alarm clock.
// Revision : 1.0 - initial release
// =============================================================================
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN         = 3'd0,
        SET_HOUR    = 3'd1,
        SET_MIN     = 3'd2,
        SET_AL_HOUR = 3'd3,
        SET_AL_MIN  = 3'd4
    } mode_t;

    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            RUN:         return SET_HOUR;
            SET_HOUR:    return SET_MIN;
            SET_MIN:     return SET_AL_HOUR;
            SET_AL_HOUR: return SET_AL_MIN;
            default:     return RUN;
        endcase
    endfunction

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// =============================================================================
// Module   : btn_edge
// Brief    : Registered rising-edge detector; history resets high so a held
//            button never produces an edge out of reset.
// Revision : 1.0 - initial release
// =============================================================================
module btn_edge (
    input  logic clk_in,
    input  logic reset,
    input  logic level_i,
    output logic edge_o
);

    logic prev_q;
    logic edge_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            prev_q <= 1'b1;
            edge_q <= 1'b0;
        end else begin
            prev_q <= level_i;
            edge_q <= level_i & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule
`default_nettype wire

// File: rtl/clock_mode_controller.sv
`default_nettype none
// =============================================================================
// Module   : clock_mode_controller
// Brief    : Alarm clock time base, mode FSM, alarm ring. Optional snooze on
//            btn_inc while ringing when CLOCK_CTRL_SNOOZE_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
module clock_mode_controller
    import clock_ctrl_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int ALARM_RST_HOUR = 6,
    parameter int SNOOZE_MINUTES = 9
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic [2:0] mode,
    output logic       blink,
    output logic       alarm_on,
    output logic       alarm_ring
);

    if (RING_SECONDS < 1 || RING_SECONDS > 255 || ALARM_RST_HOUR < 0 ||
        ALARM_RST_HOUR > 23 || SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 59) begin : g_param_check
        $error("clock_mode_controller: parameter out of range");
    end

    localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

    logic w_mode_edge, w_inc_edge, w_alarm_edge, w_any_edge;

    btn_edge u_edge_mode  (.clk_in(clk_in), .reset(reset), .level_i(btn_mode),  .edge_o(w_mode_edge));
    btn_edge u_edge_inc   (.clk_in(clk_in), .reset(reset), .level_i(btn_inc),   .edge_o(w_inc_edge));
    btn_edge u_edge_alarm (.clk_in(clk_in), .reset(reset), .level_i(btn_alarm), .edge_o(w_alarm_edge));

    assign w_any_edge = w_mode_edge | w_inc_edge | w_alarm_edge;

    mode_t      mode_q, mode_d;
    logic [4:0] hours_q, hours_d, alarm_hours_q, alarm_hours_d;
    logic [5:0] minutes_q, minutes_d, seconds_q, seconds_d, alarm_minutes_q, alarm_minutes_d;
    logic       blink_q, blink_d, alarm_on_q, alarm_on_d, ring_q, ring_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
`ifdef CLOCK_CTRL_SNOOZE_EN
    localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MINUTES * 60);
    logic [11:0] snooze_q, snooze_d;
`endif

    always_comb begin
        mode_d          = mode_q;
        hours_d         = hours_q;
        minutes_d       = minutes_q;
        seconds_d       = seconds_q;
        alarm_hours_d   = alarm_hours_q;
        alarm_minutes_d = alarm_minutes_q;
        blink_d         = blink_q;
        alarm_on_d      = alarm_on_q;
        ring_d          = ring_q;
        ring_cnt_d      = ring_cnt_q;
`ifdef CLOCK_CTRL_SNOOZE_EN
        snooze_d        = snooze_q;
`endif
        // While ringing, every button edge is swallowed as a dismiss.
        if (ring_q) begin
            if (w_any_edge) begin
                ring_d     = 1'b0;
                ring_cnt_d = '0;
`ifdef CLOCK_CTRL_SNOOZE_EN
                if (w_inc_edge) snooze_d = SNOOZE_LOAD;
`endif
            end else if (tick_1hz) begin
                if (ring_cnt_q == RING_LAST) begin
                    ring_d     = 1'b0;
                    ring_cnt_d = '0;
                end else begin
                    ring_cnt_d = ring_cnt_q + 8'd1;
                end
            end
        end else begin
            if (w_inc_edge) begin
                case (mode_q)
                    SET_HOUR:    hours_d         = 5'(wrap_inc({1'b0, hours_q}, {1'b0, HOUR_MAX}));
                    SET_MIN:     minutes_d       = wrap_inc(minutes_q, MIN_MAX);
                    SET_AL_HOUR: alarm_hours_d   = 5'(wrap_inc({1'b0, alarm_hours_q}, {1'b0, HOUR_MAX}));
                    SET_AL_MIN:  alarm_minutes_d = wrap_inc(alarm_minutes_q, MIN_MAX);
                    default: ;
                endcase
            end
            if (w_alarm_edge && mode_q == RUN) begin
                alarm_on_d = ~alarm_on_q;
`ifdef CLOCK_CTRL_SNOOZE_EN
                snooze_d   = '0;
`endif
            end
            if (w_mode_edge) begin
                mode_d = next_mode(mode_q);
                if (mode_q == SET_MIN) seconds_d = '0;
            end
        end

        if (tick_1hz && mode_q != SET_HOUR && mode_q != SET_MIN) begin
            seconds_d = wrap_inc(seconds_d, SEC_MAX);
            if (seconds_d == '0) begin
                minutes_d = wrap_inc(minutes_d, MIN_MAX);
                if (minutes_d == '0) hours_d = 5'(wrap_inc({1'b0, hours_d}, {1'b0, HOUR_MAX}));
            end
        end

        if (mode_d == RUN)          blink_d = 1'b0;
        else if (mode_d != mode_q)  blink_d = 1'b1;
        else if (tick_1hz)          blink_d = ~blink_q;

        // A mode edge in the same cycle keeps the FSM out of RUN, so no ring can start.
        if (!ring_q && tick_1hz && mode_q == RUN && mode_d == RUN && alarm_on_d &&
            hours_d == alarm_hours_d && minutes_d == alarm_minutes_d && seconds_d == '0) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
`ifdef CLOCK_CTRL_SNOOZE_EN
            snooze_d   = '0;
`endif
        end
`ifdef CLOCK_CTRL_SNOOZE_EN
        else if (!ring_q && tick_1hz && snooze_d != '0) begin
            snooze_d = snooze_d - 12'd1;
            if (snooze_d == '0) begin
                ring_d     = 1'b1;
                ring_cnt_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            mode_q          <= RUN;
            hours_q         <= '0;
            minutes_q       <= '0;
            seconds_q       <= '0;
            alarm_hours_q   <= 5'(ALARM_RST_HOUR);
            alarm_minutes_q <= '0;
            blink_q         <= 1'b0;
            alarm_on_q      <= 1'b0;
            ring_q          <= 1'b0;
            ring_cnt_q      <= '0;
`ifdef CLOCK_CTRL_SNOOZE_EN
            snooze_q        <= '0;
`endif
        end else begin
            mode_q          <= mode_d;
            hours_q         <= hours_d;
            minutes_q       <= minutes_d;
            seconds_q       <= seconds_d;
            alarm_hours_q   <= alarm_hours_d;
            alarm_minutes_q <= alarm_minutes_d;
            blink_q         <= blink_d;
            alarm_on_q      <= alarm_on_d;
            ring_q          <= ring_d;
            ring_cnt_q      <= ring_cnt_d;
`ifdef CLOCK_CTRL_SNOOZE_EN
            snooze_q        <= snooze_d;
`endif
        end
    end

    assign hours         = hours_q;
    assign minutes       = minutes_q;
    assign seconds       = seconds_q;
    assign alarm_hours   = alarm_hours_q;
    assign alarm_minutes = alarm_minutes_q;
    assign mode          = mode_q;
    assign blink         = blink_q;
    assign alarm_on      = alarm_on_q;
    assign alarm_ring    = ring_q;

endmodule
`default_nettype wire
